// File: rtl/ir_xmit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ir_xmit                                                       |
// | Purpose  : NEC-protocol IR transmitter. Encodes a 16-bit address/command |
// |            or a repeat code into a timed mark/space envelope and a       |
// |            38 kHz carrier-modulated LED drive, with busy/done handshake. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ir_xmit #(
  parameter int UNIT_CYCLES  = 15188,
  parameter int CARRIER_HALF = 355,
  parameter int GAP_UNITS    = 72
) (
  input  logic        clk27,
  input  logic        reset_n,
  input  logic [15:0] tx_code,
  input  logic        tx_repeat,
  input  logic        tx_req,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [7:0]  tx_cnt,
  output logic        ir_tx_env,
  output logic        ir_tx_mod
);

  localparam int UW = (UNIT_CYCLES  > 1) ? $clog2(UNIT_CYCLES)  : 1;
  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);
  localparam logic [7:0]    GAP_LAST  = 8'(GAP_UNITS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_REP_SPACE  = 3'd3,
    S_BIT_MARK   = 3'd4,
    S_BIT_SPACE  = 3'd5,
    S_STOP_MARK  = 3'd6,
    S_GAP        = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [UW-1:0]   unit_q, unit_d;
  logic [7:0]      dur_q, dur_d;
  logic [4:0]      bit_q, bit_d;
  logic [31:0]     sr_q, sr_d;
  logic            rep_q, rep_d;
  logic [CW-1:0]   car_q, car_d;
  logic            phase_q, phase_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            env_q, env_d;
  logic            mod_q, mod_d;

  logic            tick;
  logic            last;
  logic            mark_d;
  logic [7:0]      len_m1;

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      unit_q  <= '0;
      dur_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      rep_q   <= 1'b0;
      car_q   <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      env_q   <= 1'b0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      dur_q   <= dur_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      rep_q   <= rep_d;
      car_q   <= car_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      env_q   <= env_d;
      mod_q   <= mod_d;
    end
  end

  // Next-state logic: unit timebase, frame sequencing, carrier and outputs.
  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    dur_d   = dur_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rep_d   = rep_q;
    car_d   = car_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    tick = (unit_q == UNIT_LAST);

    // Length of the current state in units, minus one.
    case (state_q)
      S_LEAD_MARK:  len_m1 = 8'd15;
      S_LEAD_SPACE: len_m1 = 8'd7;
      S_REP_SPACE:  len_m1 = 8'd3;
      S_BIT_SPACE:  len_m1 = sr_q[0] ? 8'd2 : 8'd0;
      S_GAP:        len_m1 = GAP_LAST;
      default:      len_m1 = 8'd0;
    endcase
    last = tick && (dur_q == len_m1);

    if (state_q == S_IDLE) begin
      unit_d = '0;
      dur_d  = '0;
      // A request in the tx_done cycle waits for the next IDLE cycle.
      if (tx_req && !done_q) begin
        state_d = S_LEAD_MARK;
        sr_d    = {~tx_code[7:0], tx_code[7:0], ~tx_code[15:8], tx_code[15:8]};
        rep_d   = tx_repeat;
        bit_d   = '0;
      end
    end else begin
      unit_d = tick ? '0 : unit_q + 1'b1;
      if (last) begin
        dur_d = '0;
        case (state_q)
          S_LEAD_MARK:  state_d = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
          S_LEAD_SPACE: state_d = S_BIT_MARK;
          S_BIT_MARK:   state_d = S_BIT_SPACE;
          S_BIT_SPACE: begin
            sr_d    = sr_q >> 1;
            bit_d   = bit_q + 5'd1;
            state_d = (bit_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
          end
          S_REP_SPACE:  state_d = S_STOP_MARK;
          S_STOP_MARK:  state_d = S_GAP;
          S_GAP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
          default:      state_d = S_IDLE;
        endcase
      end else if (tick) begin
        dur_d = dur_q + 8'd1;
      end
    end

    mark_d = (state_d == S_LEAD_MARK) || (state_d == S_BIT_MARK) ||
             (state_d == S_STOP_MARK);

    // Every mark begins on a fresh carrier half-period with the carrier high.
    if (mark_d && (state_d != state_q)) begin
      car_d   = '0;
      phase_d = 1'b1;
    end else if (car_q == CAR_LAST) begin
      car_d   = '0;
      phase_d = ~phase_q;
    end else begin
      car_d   = car_q + 1'b1;
    end

    busy_d = (state_d != S_IDLE);
    env_d  = mark_d;
    mod_d  = mark_d & phase_d;
  end

  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign tx_cnt    = cnt_q;
  assign ir_tx_env = env_q;
  assign ir_tx_mod = mod_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_xmit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ir_xmit                                                    |
// | Purpose  : Self-checking bench for ir_xmit against a segment-list model  |
// |            of the NEC frame.                                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ir_xmit;

  localparam int UC  = 10;
  localparam int CH  = 2;
  localparam int GAP = 4;

  logic        clk27 = 1'b0;
  logic        reset_n;
  logic [15:0] tx_code;
  logic        tx_repeat;
  logic        tx_req;
  logic        tx_busy;
  logic        tx_done;
  logic [7:0]  tx_cnt;
  logic        ir_tx_env;
  logic        ir_tx_mod;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  cnt_exp = 8'd0;

  ir_xmit #(
    .UNIT_CYCLES  (UC),
    .CARRIER_HALF (CH),
    .GAP_UNITS    (GAP)
  ) dut (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .tx_code   (tx_code),
    .tx_repeat (tx_repeat),
    .tx_req    (tx_req),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_cnt    (tx_cnt),
    .ir_tx_env (ir_tx_env),
    .ir_tx_mod (ir_tx_mod)
  );

  // 27 MHz stand-in clock
  always #5 clk27 = ~clk27;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk27);
    #1;
  endtask

  // Send one frame and compare every cycle against the expanded segment model.
  // intr_at >= 0 pulses a conflicting request at that cycle of the frame.
  task automatic run_frame(input logic [15:0] code, input bit rep, input int intr_at);
    int          seg[$];
    bit          env_exp[$];
    bit          mod_exp[$];
    bit          obs_env[$];
    int          runs[$];
    logic [31:0] word;
    logic [31:0] dec;
    int          total;
    int          env_bad;
    int          mod_bad;
    int          busy_bad;
    int          done_bad;
    int          len;
    bit          lvl;

    word = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
    env_bad = 0; mod_bad = 0; busy_bad = 0; done_bad = 0;

    // Segment list in units, alternating mark/space starting with a mark.
    seg.push_back(16);
    if (rep) begin
      seg.push_back(4);
    end else begin
      seg.push_back(8);
      for (int i = 0; i < 32; i++) begin
        seg.push_back(1);
        seg.push_back(word[i] ? 3 : 1);
      end
    end
    seg.push_back(1);
    seg.push_back(GAP);

    for (int s = 0; s < seg.size(); s++) begin
      for (int p = 0; p < seg[s] * UC; p++) begin
        env_exp.push_back(s % 2 == 0);
        mod_exp.push_back((s % 2 == 0) && ((p / CH) % 2 == 0));
      end
    end
    total = env_exp.size();

    tx_code   = code;
    tx_repeat = rep;
    tx_req    = 1'b1;
    step();
    tx_req    = 1'b0;
    for (int k = 0; k < total; k++) begin
      obs_env.push_back(ir_tx_env === 1'b1);
      if (ir_tx_env !== env_exp[k]) env_bad++;
      if (ir_tx_mod !== mod_exp[k]) mod_bad++;
      if (tx_busy !== 1'b1) busy_bad++;
      if (tx_done !== 1'b0) done_bad++;
      if (k == intr_at) begin
        tx_req    = 1'b1;
        tx_code   = ~code;
        tx_repeat = ~rep;
      end else if (k == intr_at + 1) begin
        tx_req    = 1'b0;
      end
      step();
    end
    check("env_bad_cycles", env_bad, 0);
    check("mod_bad_cycles", mod_bad, 0);
    check("busy_low_cycles", busy_bad, 0);
    check("early_done_cycles", done_bad, 0);

    cnt_exp = cnt_exp + 8'd1;
    check("done_at_end", tx_done, 1);
    check("busy_at_end", tx_busy, 0);
    check("cnt_at_end", tx_cnt, cnt_exp);
    step();
    check("done_one_cycle", tx_done, 0);

    // Receiver-style decode of the observed envelope.
    if (!rep) begin
      len = 0;
      lvl = obs_env[0];
      foreach (obs_env[i]) begin
        if (obs_env[i] == lvl) begin
          len++;
        end else begin
          runs.push_back(len);
          lvl = obs_env[i];
          len = 1;
        end
      end
      runs.push_back(len);
      dec = 'x;
      if (runs.size() >= 66 && obs_env[0]) begin
        dec = '0;
        for (int i = 0; i < 32; i++) dec[i] = (runs[3 + 2 * i] > 2 * UC);
      end
      check("decode_word", dec, word);
    end
  endtask

  initial begin
    int blen;
    int done_seen;

    reset_n   = 1'b0;
    tx_code   = 16'h0000;
    tx_repeat = 1'b0;
    tx_req    = 1'b0;
    repeat (3) step();
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_cnt", tx_cnt, 0);
    check("rst_env", ir_tx_env, 0);
    check("rst_mod", ir_tx_mod, 0);
    reset_n = 1'b1;
    step();
    check("post_rst_busy", tx_busy, 0);
    check("post_rst_env", ir_tx_env, 0);

    // Directed frames
    run_frame(16'h00FF, 1'b0, -1);
    run_frame(16'hA55A, 1'b0, -1);
    run_frame(16'h0000, 1'b1, -1);

    // Conflicting request mid-frame must be neither obeyed nor queued
    run_frame(16'h1234, 1'b0, 300);
    step();
    check("no_queued_req", tx_busy, 0);

    // Random frames
    for (int r = 0; r < 2; r++) run_frame(16'($urandom), 1'($urandom_range(0, 1)), -1);

    // Request held high: back-to-back repeat frames, counter wraps
    tx_code   = 16'($urandom);
    tx_repeat = 1'b1;
    tx_req    = 1'b1;
    for (int f = 0; f < 256; f++) begin
      step();
      blen = 0;
      while (tx_busy === 1'b1 && blen < 1000) begin
        blen++;
        step();
      end
      check("held_busy_len", blen, 250);
      cnt_exp = cnt_exp + 8'd1;
      check("held_done", tx_done, 1);
      check("held_cnt", tx_cnt, cnt_exp);
      if (f == 255) tx_req = 1'b0;
      step();
      check("held_idle_gap", {tx_busy, tx_done}, 0);
    end
    step();
    check("held_stop", tx_busy, 0);

    // Asynchronous reset during the first bit space
    tx_code   = 16'($urandom);
    tx_repeat = 1'b0;
    tx_req    = 1'b1;
    step();
    tx_req    = 1'b0;
    for (int k = 0; k < 253; k++) step();
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_env_space", ir_tx_env, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_env", ir_tx_env, 0);
    check("async_rst_mod", ir_tx_mod, 0);
    check("async_rst_busy", tx_busy, 0);
    check("async_rst_cnt", tx_cnt, 0);
    cnt_exp = 8'd0;
    done_seen = 0;
    repeat (3) begin
      step();
      if (tx_done !== 1'b0) done_seen++;
    end
    reset_n = 1'b1;
    repeat (5) begin
      step();
      if (tx_done !== 1'b0 || tx_busy !== 1'b0) done_seen++;
    end
    check("no_resume_after_rst", done_seen, 0);
    run_frame(16'($urandom), 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
